// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit frames and buffers scancodes.
// Define PS2_KEYBOARD_FIFO_EN for a 2^FIFO_AW-entry FIFO; otherwise a single holding register is used.
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FIFO_AW        = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       parity_err,
    output logic       overflow
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity check across the eight data bits and the received parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic par_v);
        return ^{byte_v, par_v};
    endfunction

    logic [1:0]      clk_sync_r;
    logic [1:0]      dat_sync_r;
    logic            clk_prev_r;
    state_t          state_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            parity_r;
    logic [TO_W-1:0] timeout_r;
    logic            parity_err_r;
    logic [7:0]      data_r;
    logic            ready_r;
    logic            overflow_r;

    logic            fall_s;
    logic            dat_s;
    logic            timeout_hit_s;
    logic            push_s;
    logic            bad_s;
    logic            pop_s;
    logic            accept_s;
    logic            drop_s;

    // Two-flop synchronisers; lines idle high so reset them high to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
            clk_prev_r <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[0], ps2_clk};
            dat_sync_r <= {dat_sync_r[0], ps2_dat};
            clk_prev_r <= clk_sync_r[1];
        end
    end

    assign fall_s        = clk_prev_r & ~clk_sync_r[1];
    assign dat_s         = dat_sync_r[1];
    assign timeout_hit_s = (timeout_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Stop-bit qualification: a good frame pushes, anything else is rejected.
    always_comb begin
        push_s = 1'b0;
        bad_s  = 1'b0;
        if ((state_r == STOP) && fall_s) begin
            if (dat_s && odd_parity_ok(shift_r, parity_r)) begin
                push_s = 1'b1;
            end else begin
                bad_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            bad_s  = 1'b0;
        end
    end

    // Frame deserialiser with inter-edge timeout; a timeout silently drops the partial byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            parity_r     <= 1'b0;
            timeout_r    <= '0;
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= bad_s;
            if ((state_r == IDLE) || fall_s || timeout_hit_s) begin
                timeout_r <= '0;
            end else begin
                timeout_r <= timeout_r + TO_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (fall_s && !dat_s) begin
                        state_r   <= DATA;
                        bit_cnt_r <= 3'd0;
                    end
                end
                DATA: begin
                    if (fall_s) begin
                        shift_r   <= {dat_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= IDLE;
                    end
                end
                PARITY: begin
                    if (fall_s) begin
                        parity_r <= dat_s;
                        state_r  <= STOP;
                    end else if (timeout_hit_s) begin
                        state_r <= IDLE;
                    end
                end
                STOP: begin
                    if (fall_s || timeout_hit_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign pop_s = rd & ready_r;

`ifdef PS2_KEYBOARD_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [7:0]    head_next_s;
    logic          full_s;

    assign full_s   = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                      (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign accept_s = push_s & (~full_s | pop_s);
    assign drop_s   = push_s & full_s & ~pop_s;

    // Next pointers and the byte that will sit at the head after this cycle's pop/push.
    always_comb begin
        rd_ptr_next_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        wr_ptr_next_s = accept_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        if (accept_s && (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_next_s[FIFO_AW-1:0])) begin
            head_next_s = shift_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s[FIFO_AW-1:0]];
        end
    end

    // FIFO storage, pointers and registered head/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            data_r     <= 8'h00;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r[FIFO_AW-1:0]] <= shift_r;
            end
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            data_r   <= head_next_s;
            ready_r  <= (wr_ptr_next_s != rd_ptr_next_s);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (pop_s) begin
                overflow_r <= 1'b0;
            end
        end
    end
`else
    assign accept_s = push_s & (~ready_r | pop_s);
    assign drop_s   = push_s & ready_r & ~pop_s;

    // Single holding register; a same-cycle pop frees the slot for the incoming byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r     <= 8'h00;
            ready_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                data_r  <= shift_r;
                ready_r <= 1'b1;
            end else if (pop_s) begin
                ready_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (pop_s) begin
                overflow_r <= 1'b0;
            end
        end
    end
`endif

    assign data       = data_r;
    assign ready      = ready_r;
    assign parity_err = parity_err_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised bench for ps2_keyboard against a queue-based model of the receive buffer.
module tb_ps2_keyboard;

    localparam int TO  = 200;
    localparam int H   = 10;
    localparam int GAP = 40;
`ifdef PS2_KEYBOARD_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       rd;
    logic [7:0] data;
    logic       ready;
    logic       parity_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] q_m [$];
    bit         ovf_m  = 1'b0;
    int         pe_exp = 0;
    int         pe_seen = 0;
    int         pe_wide = 0;
    logic       pe_last = 1'b0;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .FIFO_AW(3)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd(rd),
        .data(data), .ready(ready), .parity_err(parity_err), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // parity_err pulse counter; a high level on two consecutive cycles is a width error.
    always @(negedge clock) begin
        if (parity_err) pe_seen <= pe_seen + 1;
        if (parity_err && pe_last) pe_wide <= pe_wide + 1;
        pe_last <= parity_err;
    end

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (q_m.size() < DEPTH) q_m.push_back(b);
        else ovf_m = 1'b1;
    endfunction

    function automatic void model_pop();
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            ovf_m = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        @(negedge clock);
        chk({tag, ".ready"}, ready, (q_m.size() > 0));
        chk({tag, ".ovf"}, overflow, ovf_m);
        chk({tag, ".perr"}, pe_seen, pe_exp);
        if (q_m.size() > 0) chk({tag, ".data"}, data, q_m[0]);
    endtask

    // Sends the first nbits of a frame; optionally strobes rd in the cycle the stop bit is taken.
    task automatic send_frame(input logic [7:0] b, input bit par_good, input bit stop,
                              input int nbits, input bit rd_at_push);
        logic [10:0] bits;
        bits = {stop, (par_good ? ~^b : ^b), b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clock); #1 ps2_dat = bits[i];
            repeat (H) @(posedge clock);
            #1 ps2_clk = 1'b0;
            for (int k = 1; k <= H; k++) begin
                @(posedge clock); #1;
                rd = (rd_at_push && i == 10 && k == 2);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (GAP) @(posedge clock);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b1, 11, 1'b0);
        model_push(b);
    endtask

    task automatic pop_one(input string tag);
        @(posedge clock); #1 rd = 1'b1;
        @(posedge clock); #1 rd = 1'b0;
        model_pop();
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (q_m.size() > 0 && guard < 20) begin
            pop_one(tag);
            guard++;
        end
        chk({tag, ".empty"}, ready, 1'b0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("rst.data", data, 8'h00);
        chk("rst.ready", ready, 1'b0);
        chk("rst.perr", parity_err, 1'b0);
        chk("rst.ovf", overflow, 1'b0);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);

        // Basic frame then pop.
        good_frame(8'h1C);
        check_all("f1c");
        pop_one("f1c_pop");

        // Wrong parity.
        send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        pe_exp++;
        check_all("perr_f0");

        // Aborted frame times out quietly, then a clean frame.
        send_frame(8'h33, 1'b1, 1'b1, 5, 1'b0);
        repeat (TO + 60) @(posedge clock);
        check_all("abort");
        good_frame(8'h5A);
        check_all("f5a");
        drain("d5a");

        // Overrun with nine frames.
        for (int i = 1; i <= 9; i++) good_frame(8'(i));
        check_all("ovr");
        chk("ovr.flag", overflow, 1'b1);
        drain("ovr_pop");

        // Reset mid-frame discards it.
        send_frame(8'h1C, 1'b1, 1'b1, 6, 1'b0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        q_m.delete();
        ovf_m = 1'b0;
        check_all("midrst");
        good_frame(8'h76);
        check_all("f76");
        drain("d76");

        // Full buffer with pop in the push cycle.
        for (int i = 0; i < DEPTH; i++) good_frame(8'($urandom_range(0, 255)));
        send_frame(8'h29, 1'b1, 1'b1, 11, 1'b1);
        model_pop();
        model_push(8'h29);
        check_all("fullpp");
        chk("fullpp.ovf0", overflow, 1'b0);
        while (q_m.size() > 1) pop_one("fullpp_pop");
        @(negedge clock);
        chk("fullpp.last", data, 8'h29);
        drain("fullpp_end");

        // Random mix of good, bad, aborted frames and pops.
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            if (r <= 4) begin
                good_frame(b);
            end else if (r == 5) begin
                send_frame(b, 1'b0, 1'b1, 11, 1'b0);
                pe_exp++;
            end else if (r == 6) begin
                send_frame(b, 1'b1, 1'b0, 11, 1'b0);
                pe_exp++;
            end else if (r == 7) begin
                send_frame(b, 1'b1, 1'b1, $urandom_range(1, 10), 1'b0);
                repeat (TO + 50) @(posedge clock);
            end else begin
                @(posedge clock); #1 rd = 1'b1;
                @(posedge clock); #1 rd = 1'b0;
                model_pop();
            end
            check_all("rnd");
        end
        drain("rnd_end");
        chk("perr.width", pe_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 25000, frame-abort timeout in clock cycles (1 ms at 25 MHz).
REQ-002 SHALL have parameter FIFO_AW, default 3, log2 of FIFO depth (8 entries).
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 SHALL have port ps2_dat  input  1  raw PS/2 data line, asynchronous.
REQ-007 SHALL have port rd  input  1  pop strobe; one byte consumed per cycle high while ready=1.
REQ-008 SHALL have port data  output  8  scancode at buffer head.
REQ-009 SHALL have port ready  output  1  buffer non-empty.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse on rejected frame.
REQ-011 SHALL have port overflow  output  1  sticky flag: a received byte was dropped.

Function
REQ-012 SHALL pass ps2_clk and ps2_dat through 2-FF synchronizers; falling edge = previous synced ps2_clk 1, current 0.
REQ-013 SHALL sample synced ps2_dat only on detected falling edges.
REQ-014 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with dat=0 -> DATA, bit count 0; dat=1 -> stay IDLE.
REQ-016 DATA: shift bits LSB first; after 8th bit -> PARITY.
REQ-017 PARITY: latch parity bit -> STOP.
REQ-018 STOP: on falling edge, dat=1 and odd parity over data+parity -> push byte; otherwise pulse parity_err, discard; always -> IDLE.
REQ-019 Timeout counter SHALL clear on every falling edge and in IDLE; in any other state, reaching TIMEOUT_CYCLES-1 -> IDLE, partial byte discarded, no parity_err.
REQ-020 Push SHALL occur at the edge where the stop-bit falling edge is detected; ready and data valid from the next cycle.
REQ-021 rd with ready=0 SHALL be ignored; data SHALL show next entry the cycle after a pop.
REQ-022 Push while full SHALL drop the new byte and set overflow; stored bytes unchanged.
REQ-023 Simultaneous push and pop while full SHALL pop first, accept push, not set overflow.
REQ-024 overflow SHALL clear on any accepted pop.
REQ-025 FIFO pointers SHALL wrap modulo 2^FIFO_AW; full/empty distinguished by an extra pointer bit.

Reset
REQ-026 reset SHALL force IDLE, clear counters, shift register, pointers; outputs data=0x00, ready=0, parity_err=0, overflow=0.
REQ-027 reset asserted mid-frame SHALL discard the frame; reception resumes at the next start bit after release.

Configuration
REQ-028 Macro PS2_KEYBOARD_FIFO_EN defined: FIFO of 2^FIFO_AW entries per REQ-022..025.
REQ-029 Macro undefined: single holding register; ready set on push, cleared on pop; push while ready=1 without same-cycle rd drops new byte, sets overflow; FIFO_AW ignored.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, 12.5 kHz PS/2 clock -> ready=1, data=0x1C; rd pulse -> ready=0 next cycle.
REQ-031 Frame 0xF0 with parity 0 (wrong) -> parity_err one-cycle pulse, ready stays 0.
REQ-032 Start + 4 data bits then clock idle 1.2 ms, then full frame 0x5A -> no parity_err, ready=1, data=0x5A.
REQ-033 FIFO_EN: frames 0x01..0x09 without rd -> overflow=1; eight pops return 0x01..0x08, then ready=0.
REQ-034 reset pulsed after bit 5 of frame 0x1C, then full frame 0x76 -> only 0x76 delivered, overflow=0.
REQ-035 FIFO full, rd asserted in push cycle of frame 0x29 -> overflow stays 0, 0x29 read last.
